// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared constants, count-width helper and flag bundle for the UART FIFOs
package uart_fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_FIFO_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic trig;
    logic overflow;
    logic underflow;
  } uart_fifo_flags_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port array, synchronous write and asynchronous read
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_fifo_ctl.sv
// uart_fifo_ctl: parametrised UART byte FIFO with level flags, flush and sticky errors
module uart_fifo_ctl
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int FWFT = 0,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     count,
  input  logic [CW-1:0]     trig_lvl,
  output logic              trig,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic rd_valid_q, rd_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic rd_ok, wr_ok, rd_acc, wr_acc;
  uart_fifo_flags_t flags;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    flags.full = count_q == CW'(DEPTH);
    flags.empty = count_q == '0;
    flags.almost_full = int'(count_q) >= DEPTH - AF_MARGIN;
    flags.almost_empty = int'(count_q) <= AE_MARGIN;
    flags.trig = (trig_lvl != '0) && (count_q >= trig_lvl);
    flags.overflow = ovf_q;
    flags.underflow = unf_q;
  end
  always_comb begin
    rd_ok = rd_en & ~flags.empty;
    wr_ok = wr_en & (~flags.full | rd_ok);
    rd_acc = rd_ok & ~flush;
    wr_acc = wr_ok & ~flush;
    wr_ptr_d = flush ? '0 : wr_acc ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : rd_acc ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d = flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
    rd_data_d = rd_acc ? ram_rdata : rd_data_q;
    rd_valid_d = rd_acc;
    ovf_d = (~flush & wr_en & ~wr_ok) | (ovf_q & ~clr_err);
    unf_d = (~flush & rd_en & flags.empty) | (unf_q & ~clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  uart_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(wr_acc),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );
  assign rd_data = (FWFT != 0) ? ram_rdata : rd_data_q;
  assign rd_valid = (FWFT != 0) ? ~flags.empty : rd_valid_q;
  assign count = count_q;
  assign trig = flags.trig;
  assign full = flags.full;
  assign empty = flags.empty;
  assign almost_full = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign overflow = flags.overflow;
  assign underflow = flags.underflow;
endmodule

// File: tb/tb_uart_fifo_ctl.sv
// tb_uart_fifo_ctl: directed and table-driven checks of uart_fifo_ctl in three configurations
module tb_uart_fifo_ctl;
  logic clk = 1'b0;
  logic rst, flush, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [4:0] tl;
  logic [7:0] a_rd_data, b_rd_data, c_rd_data;
  logic [4:0] a_count;
  logic [2:0] b_count, c_count;
  logic a_rd_valid, a_trig, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic b_rd_valid, b_trig, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic c_rd_valid, c_trig, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  int pass_n = 0;
  int tot_n = 0;
  typedef struct {
    logic w, r, c;
    logic [7:0] d;
    logic [2:0] cnt;
    logic [5:0] fl;
    logic v;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [19];
  always #5 clk = ~clk;
  uart_fifo_ctl #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count), .trig_lvl(tl), .trig(a_trig),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
  );
  uart_fifo_ctl #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count), .trig_lvl(tl[2:0]), .trig(b_trig),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
  );
  uart_fifo_ctl #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid), .count(c_count), .trig_lvl(tl[2:0]), .trig(c_trig),
    .full(c_full), .empty(c_empty), .almost_full(c_af), .almost_empty(c_ae),
    .overflow(c_ovf), .underflow(c_unf), .clr_err(clr_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic cyc(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    flush = f;
    clr_err = c;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    clr_err = 1'b0;
    wr_data = 8'h00;
    tl = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 6'b000100, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h12, 3'd2, 6'b000100, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h13, 3'd3, 6'b001000, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h14, 3'd4, 6'b001000, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h15, 3'd5, 6'b101000, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h77, 3'd5, 6'b101010, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd5, 6'b101000, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h55, 3'd5, 6'b101000, 1'b1, 8'h11};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 6'b001000, 1'b1, 8'h12};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 6'b001000, 1'b1, 8'h13};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 6'b000100, 1'b1, 8'h14};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 6'b000100, 1'b1, 8'h15};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010100, 1'b1, 8'h55};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h66, 3'd1, 6'b000101, 1'b0, 8'h55};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 6'b000100, 1'b0, 8'h55};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010100, 1'b1, 8'h66};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010101, 1'b0, 8'h66};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 6'b010101, 1'b0, 8'h66};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 6'b010100, 1'b0, 8'h66};
    do_reset();
    chk("reset_count", a_count, 0);
    chk("reset_flags", {a_full, a_empty, a_af, a_ae, a_trig, a_ovf, a_unf}, 7'b0101000);
    chk("reset_rd", {a_rd_valid, a_rd_data}, 9'h000);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    chk("fill_count", a_count, 16);
    chk("fill_full", {a_full, a_empty, a_ovf}, 3'b100);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
    chk("wr17_count", a_count, 16);
    chk("wr17_ovf", a_ovf, 1);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("drain_valid", a_rd_valid, 1);
      chk("drain_data", a_rd_data, i);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_end", {a_rd_valid, a_empty, a_rd_data}, {2'b01, 8'h10});
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i));
      chk("wrap_cnt_w", b_count, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("wrap_data", {b_rd_valid, b_rd_data}, {1'b1, 8'hA0 + 8'(i)});
      chk("wrap_cnt_r", b_count, 0);
    end
    chk("wrap_err", {b_ovf, b_unf}, 2'b00);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].w, tbl[i].r, 1'b0, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), b_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_flags", i), {b_full, b_empty, b_af, b_ae, b_ovf, b_unf}, tbl[i].fl);
      chk($sformatf("tbl%0d_valid", i), b_rd_valid, tbl[i].v);
      chk($sformatf("tbl%0d_rdata", i), b_rd_data, tbl[i].rd);
    end
    do_reset();
    chk("fwft_reset", {c_rd_valid, c_empty}, 2'b01);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    chk("fwft_first", {c_rd_valid, c_rd_data}, {1'b1, 8'h3C});
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("fwft_hold", {c_rd_valid, c_rd_data}, {1'b1, 8'h3C});
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h4D);
    chk("fwft_head", {c_count, c_rd_data}, {3'd2, 8'h3C});
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("fwft_pop1", {c_rd_valid, c_rd_data}, {1'b1, 8'h4D});
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("fwft_pop2", {c_rd_valid, c_empty, c_unf}, 3'b010);
    do_reset();
    tl = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      chk("trig_rise", a_trig, (i >= 4) ? 1 : 0);
    end
    for (int i = 5; i <= 14; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      if (i >= 13) chk("af_rise", a_af, (i >= 14) ? 1 : 0);
    end
    tl = 5'd0;
    #1 chk("trig_off", a_trig, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd15);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd16);
    tl = 5'd17;
    #1 chk("trig_over", a_trig, 0);
    tl = 5'd16;
    #1 chk("trig_full", a_trig, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("pre_flush", {a_count, a_rd_data}, {5'd15, 8'h01});
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
    chk("flush_count", a_count, 0);
    chk("flush_state", {a_empty, a_rd_valid, a_ovf, a_unf, a_rd_data}, {4'b1000, 8'h01});
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h21 + 8'(i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h28);
    chk("burst_state", {a_count, a_rd_valid, a_rd_data}, {5'd7, 1'b1, 8'h21});
    #2 rst = 1'b1;
    #1 chk("async_rst", {a_count, a_empty, a_ae, a_rd_valid, a_rd_data}, {5'd0, 3'b110, 8'h00});
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("post_rst", {a_count, a_rd_valid, a_rd_data}, {5'd0, 1'b1, 8'h5A});
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
